// File: rtl/mdio_pkg.sv
// Shared Clause-22 MDIO frame constants, field widths and responder state encoding.
package mdio_pkg;

  localparam logic [1:0] ST_BITS = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  // Bit-counter end values: address fields, write data, read data + release edge, TA + data skip.
  localparam logic [4:0] ADDR_LAST = 5'(PHYAD_W - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
  localparam logic [4:0] RD_LAST   = 5'(DATA_W);
  localparam logic [4:0] SKIP_LAST = 5'(DATA_W + 1);

  typedef enum logic [3:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } state_e;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer with a third alignment flop; emits either the aligned level
// or a one-clock pulse on a rising input, both with identical latency.
module mdio_sync_edge #(
  parameter bit RISE_DET = 1'b0
) (
  input  logic clk_app_i,
  input  logic rst_clk_app_n,
  input  logic i_async,
  output logic o_q
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  generate
    if (RISE_DET) begin : g_rise
      logic r_rise;
      always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
        if (!rst_clk_app_n) r_rise <= 1'b0;
        else                r_rise <= r_sync & ~r_prev;
      end
      assign o_q = r_rise;
    end else begin : g_level
      assign o_q = r_prev;
    end
  endgenerate

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO, decodes frames for PHY_ADDR and
// turns them into single-cycle read/write strobes on a 32x16 register port.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32,
  parameter bit         BCAST_WR_EN  = 1'b1
) (
  input  logic        clk_app_i,
  input  logic        rst_clk_app_n,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic [4:0]  o_reg_addr,
  output logic [15:0] o_reg_wdata,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  input  logic [15:0] i_reg_rdata,
  output logic        o_frame_err
);

  localparam logic [5:0] ONES_MAX = 6'(PREAMBLE_LEN);

  logic w_mdc_rise;
  logic w_bit;

  mdio_sync_edge #(.RISE_DET(1'b1)) u_sync_mdc (
    .clk_app_i     (clk_app_i),
    .rst_clk_app_n (rst_clk_app_n),
    .i_async       (i_mdc),
    .o_q           (w_mdc_rise)
  );

  mdio_sync_edge #(.RISE_DET(1'b0)) u_sync_mdio (
    .clk_app_i     (clk_app_i),
    .rst_clk_app_n (rst_clk_app_n),
    .i_async       (i_mdio),
    .o_q           (w_bit)
  );

  state_e              r_state, w_state_next;
  logic [4:0]          r_bit_cnt, w_bit_cnt_next;
  logic [5:0]          r_ones, w_ones_next;
  logic                r_op_hi, w_op_hi_next;
  logic                r_is_read, w_is_read_next;
  logic [PHYAD_W-1:0]  r_phyad, w_phyad_next;
  logic [REGAD_W-1:0]  r_regad, w_regad_next;
  logic [DATA_W-1:0]   r_shift, w_shift_next;
  logic                r_mdio, w_mdio_next;
  logic                r_oe, w_oe_next;
  logic [REGAD_W-1:0]  r_reg_addr, w_reg_addr_next;
  logic [DATA_W-1:0]   r_reg_wdata, w_reg_wdata_next;
  logic                r_reg_wr, w_reg_wr_next;
  logic                r_reg_rd, w_reg_rd_next;
  logic                r_frame_err, w_frame_err_next;
  logic                w_err;

  logic [1:0]          w_op;
  logic [REGAD_W-1:0]  w_regad_full;
  logic                w_match;

  assign w_op         = {r_op_hi, w_bit};
  assign w_regad_full = {r_regad[REGAD_W-2:0], w_bit};
  // Reads to address 0 are never answered, even if PHY_ADDR is 0.
  assign w_match = r_is_read ? (r_phyad == PHY_ADDR && r_phyad != 5'd0)
                             : (r_phyad == PHY_ADDR || (BCAST_WR_EN && r_phyad == 5'd0));

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) r_state <= S_PRE;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    if (w_mdc_rise) begin
      case (r_state)
        S_PRE:   if (w_bit == ST_BITS[1] && r_ones == ONES_MAX) w_state_next = S_ST;
        S_ST:    if (w_bit == ST_BITS[0]) w_state_next = S_OP;
                 else                     w_err = 1'b1;
        S_OP:    if (r_bit_cnt == 5'd1) begin
                   if (w_op == OP_RD || w_op == OP_WR) w_state_next = S_PHYAD;
                   else                                w_err = 1'b1;
                 end
        S_PHYAD: if (r_bit_cnt == ADDR_LAST) w_state_next = S_REGAD;
        S_REGAD: if (r_bit_cnt == ADDR_LAST) w_state_next = w_match ? S_TA : S_SKIP;
        S_TA: begin
          if (r_is_read)               w_state_next = S_RDATA;
          else if (r_bit_cnt == 5'd0) w_err = ~w_bit;
          else if (w_bit)              w_err = 1'b1;
          else                         w_state_next = S_WDATA;
        end
        S_WDATA: if (r_bit_cnt == DATA_LAST) w_state_next = S_PRE;
        S_RDATA: if (r_bit_cnt == RD_LAST)   w_state_next = S_PRE;
        S_SKIP:  if (r_bit_cnt == SKIP_LAST) w_state_next = S_PRE;
        default: w_state_next = S_PRE;
      endcase
      if (w_err) w_state_next = S_PRE;
    end
  end

  always_comb begin
    w_bit_cnt_next   = r_bit_cnt;
    w_ones_next      = r_ones;
    w_op_hi_next     = r_op_hi;
    w_is_read_next   = r_is_read;
    w_phyad_next     = r_phyad;
    w_regad_next     = r_regad;
    w_shift_next     = r_shift;
    w_mdio_next      = r_mdio;
    w_oe_next        = r_oe;
    w_reg_addr_next  = r_reg_addr;
    w_reg_wdata_next = r_reg_wdata;
    w_reg_wr_next    = 1'b0;
    w_reg_rd_next    = 1'b0;
    w_frame_err_next = 1'b0;
    if (w_mdc_rise) begin
      w_bit_cnt_next = (w_state_next != r_state || r_state == S_PRE) ? 5'd0 : r_bit_cnt + 5'd1;
      // Ones are counted in every state so a preamble may follow a frame immediately.
      if (w_err)      w_ones_next = 6'd0;
      else if (w_bit) w_ones_next = (r_ones == ONES_MAX) ? r_ones : r_ones + 6'd1;
      else            w_ones_next = 6'd0;
      case (r_state)
        S_OP: begin
          if (r_bit_cnt == 5'd0) w_op_hi_next   = w_bit;
          else                   w_is_read_next = (w_op == OP_RD);
        end
        S_PHYAD: w_phyad_next = {r_phyad[PHYAD_W-2:0], w_bit};
        S_REGAD: begin
          w_regad_next = w_regad_full;
          if (r_bit_cnt == ADDR_LAST && w_match && r_is_read) begin
            w_reg_addr_next = w_regad_full;
            w_reg_rd_next   = 1'b1;
          end
        end
        S_TA: begin
          if (r_is_read) begin
            w_shift_next = i_reg_rdata;
            w_oe_next    = 1'b1;
            w_mdio_next  = 1'b0;
          end
        end
        S_RDATA: begin
          if (r_bit_cnt == RD_LAST) begin
            w_oe_next   = 1'b0;
            w_mdio_next = 1'b0;
          end else begin
            w_mdio_next  = r_shift[DATA_W-1];
            w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
          end
        end
        S_WDATA: begin
          w_shift_next = {r_shift[DATA_W-2:0], w_bit};
          if (r_bit_cnt == DATA_LAST) begin
            w_reg_wdata_next = {r_shift[DATA_W-2:0], w_bit};
            w_reg_addr_next  = r_regad;
            w_reg_wr_next    = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_err) begin
        w_frame_err_next = 1'b1;
        w_oe_next        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      r_bit_cnt   <= 5'd0;
      r_ones      <= 6'd0;
      r_op_hi     <= 1'b0;
      r_is_read   <= 1'b0;
      r_phyad     <= '0;
      r_regad     <= '0;
      r_shift     <= '0;
      r_mdio      <= 1'b0;
      r_oe        <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_bit_cnt   <= w_bit_cnt_next;
      r_ones      <= w_ones_next;
      r_op_hi     <= w_op_hi_next;
      r_is_read   <= w_is_read_next;
      r_phyad     <= w_phyad_next;
      r_regad     <= w_regad_next;
      r_shift     <= w_shift_next;
      r_mdio      <= w_mdio_next;
      r_oe        <= w_oe_next;
      r_reg_addr  <= w_reg_addr_next;
      r_reg_wdata <= w_reg_wdata_next;
      r_reg_wr    <= w_reg_wr_next;
      r_reg_rd    <= w_reg_rd_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign o_mdio      = r_mdio;
  assign o_mdio_oe   = r_oe;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_wr    = r_reg_wr;
  assign o_reg_rd    = r_reg_rd;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: bit-level MDIO master, strobe monitor, per-feature tasks.
module tb_mdio_responder;

  logic        clk_app_i = 1'b0;
  logic        rst_clk_app_n = 1'b0;
  logic        mdc = 1'b0;
  logic        m_oe = 1'b1;
  logic        m_bit = 1'b1;
  logic        bus;
  logic        o_mdio, o_mdio_oe, o_reg_wr, o_reg_rd, o_frame_err;
  logic [4:0]  o_reg_addr;
  logic [15:0] o_reg_wdata;
  logic [15:0] i_reg_rdata = 16'hDEAD;
  logic [15:0] rdata_resp = 16'h0000;

  int checks = 0;
  int errors = 0;
  int oe_cycles = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  logic [4:0]  wr_addr = 5'd0;
  logic [15:0] wr_data = 16'd0;

  always #5 clk_app_i = ~clk_app_i;

  // Open-drain style bus with pull-up: responder wins while it drives.
  assign bus = o_mdio_oe ? o_mdio : (m_oe ? m_bit : 1'b1);

  mdio_responder #(
    .PHY_ADDR     (5'd1),
    .PREAMBLE_LEN (32),
    .BCAST_WR_EN  (1'b1)
  ) dut (
    .clk_app_i     (clk_app_i),
    .rst_clk_app_n (rst_clk_app_n),
    .i_mdc         (mdc),
    .i_mdio        (bus),
    .o_mdio        (o_mdio),
    .o_mdio_oe     (o_mdio_oe),
    .o_reg_addr    (o_reg_addr),
    .o_reg_wdata   (o_reg_wdata),
    .o_reg_wr      (o_reg_wr),
    .o_reg_rd      (o_reg_rd),
    .i_reg_rdata   (i_reg_rdata),
    .o_frame_err   (o_frame_err)
  );

  always @(negedge clk_app_i) begin
    if (o_mdio_oe) oe_cycles++;
    if (o_reg_wr) begin
      wr_cnt++;
      wr_addr = o_reg_addr;
      wr_data = o_reg_wdata;
    end
    if (o_reg_rd) begin
      rd_cnt++;
      i_reg_rdata <= rdata_resp;
    end
    if (o_frame_err) err_cnt++;
  end

  // One MDC period: drive during low phase, sample the bus just before the rising edge.
  task automatic mdc_bit(input logic drive, input logic b, output logic s);
    mdc   = 1'b0;
    m_oe  = drive;
    m_bit = b;
    #50;
    s   = bus;
    mdc = 1'b1;
    #50;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [1:0] ta, input logic [15:0] data, input int pre_len,
                            input int rst_at, output logic ta2, output logic [15:0] rdw,
                            output logic oe_rst);
    logic        s;
    logic [13:0] hdr;
    hdr    = {2'b01, op, phy, regad};
    ta2    = 1'b1;
    rdw    = 16'd0;
    oe_rst = 1'b1;
    $display("frame op=%b phy=%0d reg=%h ta=%b data=%h pre=%0d", op, phy, regad, ta, data, pre_len);
    for (int i = 0; i < pre_len; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], s);
    if (op == 2'b10) begin
      mdc_bit(1'b0, 1'b1, s);
      mdc_bit(1'b0, 1'b1, ta2);
      for (int k = 0; k < 16; k++) begin
        if (k == rst_at) begin
          rst_clk_app_n = 1'b0;
          #1 oe_rst = o_mdio_oe;
          mdc   = 1'b0;
          m_oe  = 1'b1;
          m_bit = 1'b1;
          #40 rst_clk_app_n = 1'b1;
          #100;
          return;
        end
        mdc_bit(1'b0, 1'b1, s);
        rdw = {rdw[14:0], s};
      end
    end else begin
      mdc_bit(1'b1, ta[1], s);
      mdc_bit(1'b1, ta[0], s);
      for (int k = 15; k >= 0; k--) mdc_bit(1'b1, data[k], s);
    end
    mdc   = 1'b0;
    m_oe  = 1'b1;
    m_bit = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    checks++; if (o_mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", o_mdio_oe); end
    checks++; if (o_mdio !== 1'b0) begin errors++; $display("FAIL reset_mdio: got %b want 0", o_mdio); end
    checks++; if (o_reg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h want 00", o_reg_addr); end
    checks++; if (o_reg_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0000", o_reg_wdata); end
    checks++; if (o_reg_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", o_reg_wr); end
    checks++; if (o_reg_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", o_reg_rd); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
  endtask

  task automatic test_write();
    int w0, r0, e0, o0;
    logic ta2, orst;
    logic [15:0] rdw;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cycles;
    send_frame(2'b01, 5'd1, 5'h04, 2'b10, 16'hA5C3, 32, -1, ta2, rdw, orst);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_strobe: got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 5'h04) begin errors++; $display("FAIL write_addr: got %h want 04", wr_addr); end
    checks++; if (wr_data !== 16'hA5C3) begin errors++; $display("FAIL write_data: got %h want a5c3", wr_data); end
    checks++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL write_oe: got %0d want 0", oe_cycles - o0); end
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL write_rd: got %0d want 0", rd_cnt - r0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL write_err: got %0d want 0", err_cnt - e0); end
    checks++; if (o_reg_wdata !== 16'hA5C3) begin errors++; $display("FAIL write_hold: got %h want a5c3", o_reg_wdata); end
  endtask

  task automatic test_read();
    int r0, o0;
    logic ta2, orst;
    logic [15:0] rdw;
    r0 = rd_cnt; o0 = oe_cycles;
    rdata_resp = 16'h0141;
    send_frame(2'b10, 5'd1, 5'h02, 2'b00, 16'h0000, 32, -1, ta2, rdw, orst);
    checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_strobe: got %0d want 1", rd_cnt - r0); end
    checks++; if (o_reg_addr !== 5'h02) begin errors++; $display("FAIL read_addr: got %h want 02", o_reg_addr); end
    checks++; if (ta2 !== 1'b0) begin errors++; $display("FAIL read_ta2: got %b want 0", ta2); end
    checks++; if (rdw !== 16'h0141) begin errors++; $display("FAIL read_data: got %h want 0141", rdw); end
    checks++; if (o_mdio_oe !== 1'b0) begin errors++; $display("FAIL read_release: got %b want 0", o_mdio_oe); end
    checks++; if (oe_cycles - o0 < 100) begin errors++; $display("FAIL read_drive: got %0d cycles want >=100", oe_cycles - o0); end
  endtask

  task automatic test_other_phy();
    int w0, r0, e0, o0;
    logic ta2, orst;
    logic [15:0] rdw;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cycles;
    send_frame(2'b10, 5'd3, 5'h07, 2'b00, 16'h0000, 32, -1, ta2, rdw, orst);
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL other_rd: got %0d want 0", rd_cnt - r0); end
    checks++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL other_oe: got %0d want 0", oe_cycles - o0); end
    checks++; if (rdw !== 16'hFFFF) begin errors++; $display("FAIL other_bus: got %h want ffff", rdw); end
    send_frame(2'b01, 5'd1, 5'h09, 2'b10, 16'h1234, 32, -1, ta2, rdw, orst);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL after_other_wr: got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 5'h09 || wr_data !== 16'h1234) begin errors++; $display("FAIL after_other_data: got %h/%h want 09/1234", wr_addr, wr_data); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL other_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_errors();
    int w0, e0;
    logic ta2, orst;
    logic [15:0] rdw;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(2'b01, 5'd1, 5'h05, 2'b10, 16'hFFFF, 31, -1, ta2, rdw, orst);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL short_pre_wr: got %0d want 0", wr_cnt - w0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL short_pre_err: got %0d want 0", err_cnt - e0); end
    send_frame(2'b11, 5'd1, 5'h00, 2'b10, 16'h0000, 32, -1, ta2, rdw, orst);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_op_err: got %0d want 1", err_cnt - e0); end
    send_frame(2'b01, 5'd1, 5'h06, 2'b00, 16'h5555, 32, -1, ta2, rdw, orst);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL bad_ta_err: got %0d want 2", err_cnt - e0); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL bad_ta_wr: got %0d want 0", wr_cnt - w0); end
    checks++; if (o_reg_wdata !== 16'h1234 || o_reg_addr !== 5'h09) begin errors++; $display("FAIL bad_ta_hold: got %h/%h want 09/1234", o_reg_addr, o_reg_wdata); end
  endtask

  task automatic test_bcast();
    int w0, r0, o0;
    logic ta2, orst;
    logic [15:0] rdw;
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cycles;
    send_frame(2'b01, 5'd0, 5'h03, 2'b10, 16'hBEEF, 32, -1, ta2, rdw, orst);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL bcast_wr: got %0d want 1", wr_cnt - w0); end
    checks++; if (wr_addr !== 5'h03 || wr_data !== 16'hBEEF) begin errors++; $display("FAIL bcast_data: got %h/%h want 03/beef", wr_addr, wr_data); end
    send_frame(2'b10, 5'd0, 5'h03, 2'b00, 16'h0000, 32, -1, ta2, rdw, orst);
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL bcast_rd: got %0d want 0", rd_cnt - r0); end
    checks++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL bcast_oe: got %0d want 0", oe_cycles - o0); end
  endtask

  task automatic test_reset_mid_read();
    int w0, r0, e0;
    logic ta2, orst;
    logic [15:0] rdw;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    rdata_resp = 16'h5A3C;
    send_frame(2'b10, 5'd1, 5'h01, 2'b00, 16'h0000, 32, 7, ta2, rdw, orst);
    checks++; if (orst !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", orst); end
    checks++; if (o_reg_addr !== 5'd0 || o_reg_wdata !== 16'd0) begin errors++; $display("FAIL rst_regs: got %h/%h want 00/0000", o_reg_addr, o_reg_wdata); end
    checks++; if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL rst_strobes: got wr %0d err %0d want 0/0", wr_cnt - w0, err_cnt - e0); end
    rdata_resp = 16'h8001;
    send_frame(2'b10, 5'd1, 5'h1F, 2'b00, 16'h0000, 32, -1, ta2, rdw, orst);
    checks++; if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL post_rst_rd: got %0d want 2", rd_cnt - r0); end
    checks++; if (rdw !== 16'h8001) begin errors++; $display("FAIL post_rst_data: got %h want 8001", rdw); end
    checks++; if (o_reg_addr !== 5'h1F) begin errors++; $display("FAIL post_rst_addr: got %h want 1f", o_reg_addr); end
  endtask

  initial begin
    #3;
    #100;
    test_reset();
    rst_clk_app_n = 1'b1;
    #200;
    test_write();
    test_read();
    test_other_phy();
    test_errors();
    test_bcast();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

Clause-22 MDIO management responder (PHY-side end of the MDIO bus), oversampling MDC/MDIO in the system clock domain. Decodes read/write frames addressed to its PHY address and exposes them as single-cycle strobes on a 32×16-bit local register port. Lets the FPGA fabric act as a management target, e.g. a PHY model or a control register bank behind the MAC's MDIO master.

## Interface
Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to
- PREAMBLE_LEN, 32, consecutive 1-bits required before ST is accepted (1..32)
- BCAST_WR_EN, 1, accept writes to PHYAD 0 (reads to 0 never answered)

Ports:
- clk_app_i  in  1  system clock, ≥ 8× MDC frequency
- rst_clk_app_n  in  1  asynchronous active-low reset
- i_mdc  in  1  MDC from master, asynchronous
- i_mdio  in  1  MDIO pad input, asynchronous
- o_mdio  out  1  MDIO output value, valid when o_mdio_oe
- o_mdio_oe  out  1  MDIO drive enable (pad tristate handled outside)
- o_reg_addr  out  5  REGAD of current frame
- o_reg_wdata  out  16  write data, valid with o_reg_wr
- o_reg_wr  out  1  one-cycle write strobe
- o_reg_rd  out  1  one-cycle read strobe
- i_reg_rdata  in  16  read data; must be valid ≤ 4 clk_app_i after o_reg_rd and held until next strobe
- o_frame_err  out  1  one-cycle pulse on a malformed frame

## Operation
- i_mdc and i_mdio each pass a 2-FF synchronizer; MDC rising edge detected with one extra FF. All MDIO sampling and drive updates occur only on a detected MDC rising edge (the "edge").
- States: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
- PRE: ones counter (saturates at PREAMBLE_LEN); a 0 with counter = PREAMBLE_LEN → ST (the 0 is ST bit 1); a 0 otherwise clears counter.
- ST: sample must be 1, else error. OP: 2 bits; 10 = read, 01 = write; 00/11 → error.
- PHYAD, REGAD: 5 bits each, MSB first. At last REGAD edge: match = (PHYAD==PHY_ADDR) or (write && PHYAD==0 && BCAST_WR_EN). Read+match → o_reg_rd pulse, o_reg_addr updated. No match → SKIP for 18 edges, never drives.
- TA, write: expect 1 then 0; mismatch → error, no write. TA, read: first TA edge, latch i_reg_rdata into shift register and drive o_mdio_oe=1, o_mdio=0; then RDATA.
- RDATA: on each of 16 edges present next bit D15..D0; on edge after D0 drive released (oe=0) → PRE.
- WDATA: 16 edges shift in; on 16th edge o_reg_wdata loaded, o_reg_wr pulses → PRE.
- Error: o_frame_err pulse, oe=0, → PRE with ones counter cleared.
- Ones counter keeps counting across SKIP/WDATA/RDATA end so back-to-back frames with preamble are accepted.
- Reset (any time, mid-frame included): state PRE, counter 0, o_mdio_oe=0, o_mdio=0, o_reg_addr=0, o_reg_wdata=0, strobes 0, o_frame_err 0; frame in progress abandoned without strobes.
- MDC stalling mid-frame: state held indefinitely; no timeout.

## Timing
- Edge detected 3 clk_app_i after MDC pin rise; o_mdio/o_mdio_oe registered, change 4 clk after pin rise (40 ns at 100 MHz, within 300 ns Clause-22 limit).
- MDC high and low phases each ≥ 3 clk_app_i.
- o_reg_rd asserted 1 clk after last REGAD edge; rdata captured one MDC period later (≥ 8 clk).
- o_reg_wr asserted 1 clk after D0 edge, o_reg_wdata/o_reg_addr stable from that cycle until next frame's strobe.
- Strobes and o_frame_err exactly one clk wide.

## Structure
- Package mdio_pkg: ST/opcode constants (ST=2'b01, OP_RD=2'b10, OP_WR=2'b01), state enum, field widths (5/5/16).
- Sub-module mdio_sync_edge: 2-FF synchronizer plus rising-edge detect, instantiated for MDC (edge used) and MDIO (level used).

## Test plan
- Write PHYAD=1, REGAD=5'h04, data 16'hA5C3, 32-bit preamble → single o_reg_wr, o_reg_addr=04, o_reg_wdata=A5C3; o_mdio_oe never set.
- Read PHYAD=1, REGAD=5'h02, i_reg_rdata=16'h0141 → o_reg_rd once; TA second bit 0, master samples 0x0141 MSB first; oe drops after D0.
- Read to PHYAD=3 → no strobes, oe stays 0; following valid frame decoded correctly.
- Preamble of 31 ones then write → ignored; o_frame_err pulses on OP=11 frame; write with TA=00 → err, no o_reg_wr.
- Broadcast write PHYAD=0 with BCAST_WR_EN=1 → write accepted; read to PHYAD 0 → no drive.
- Assert rst_clk_app_n low during RDATA bit D8 → oe=0 immediately, no strobes; next full read returns correct data.
